// File: rtl/time_bcd_converter_pkg.sv
// Shared tempsense definitions for the elapsed-time BCD conversion path.
package time_bcd_converter_pkg;

    localparam int unsigned TIME_BIN_WIDTH  = 16;
    localparam int unsigned TIME_BCD_DIGITS = 5;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble of 5 or more.
module bcd_nibble_adj
    import time_bcd_converter_pkg::*;
(
    input  bcd_digit_t nib,
    output bcd_digit_t nib_adj
);

    always_comb begin
        nib_adj = (nib >= 4'd5) ? bcd_digit_t'(nib + 4'd3) : nib;
    end

endmodule

// File: rtl/time_bcd_converter.sv
// Sequential double-dabble of the elapsed-seconds value into packed BCD,
// one bit per clock, with a leading-zero blanking mask for the display stage.
module time_bcd_converter
    import time_bcd_converter_pkg::*;
#(
    parameter int unsigned BIN_WIDTH   = TIME_BIN_WIDTH,
    parameter int unsigned DIGITS      = TIME_BCD_DIGITS,
    parameter bit          AUTO_UPDATE = 1'b1
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic [BIN_WIDTH-1:0]  BIN,
    input  logic                  BIN_OVFL,
    input  logic                  CONV_START,
    output logic                  BUSY,
    output logic [4*DIGITS-1:0]   BCD_OUT,
    output logic [DIGITS-1:0]     BLANK,
    output logic                  OVFL_OUT,
    output logic                  BCD_VALID
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    conv_state_e            state_q;
    conv_state_e            state_d;
    logic [BIN_WIDTH-1:0]   bin_sr;
    logic [BIN_WIDTH-1:0]   last_bin;
    logic [BCD_W-1:0]       bcd_sr;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       cnt;
    logic                   ovfl_cap;
    logic                   last_ovfl;
    logic                   start_c;
    logic                   load_c;
    logic                   shift_c;
    logic                   publish_c;
    logic                   lz_run;
    logic [DIGITS-1:0]      blank_c;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib     (bcd_sr[4*d +: 4]),
            .nib_adj (bcd_adj[4*d +: 4])
        );
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        publish_c = 1'b0;
        start_c   = CONV_START |
                    (AUTO_UPDATE && ((BIN != last_bin) || (BIN_OVFL != last_ovfl)));
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    load_c  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_c = 1'b1;
                if (cnt == CNT_W'(BIN_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                publish_c = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Leading-zero mask: a digit blanks only if it and every higher digit are zero
    always_comb begin
        blank_c = '0;
        lz_run  = 1'b1;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            lz_run     = lz_run & (bcd_sr[4*k +: 4] == 4'd0);
            blank_c[k] = lz_run;
        end
    end

    assign BUSY = (state_q != ST_IDLE);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            bin_sr    <= '0;
            bcd_sr    <= '0;
            cnt       <= '0;
            ovfl_cap  <= 1'b0;
            last_bin  <= '0;
            last_ovfl <= 1'b0;
            BCD_OUT   <= '0;
            BLANK     <= BLANK_RST;
            OVFL_OUT  <= 1'b0;
            BCD_VALID <= 1'b0;
        end else begin
            BCD_VALID <= publish_c;
            if (load_c) begin
                bin_sr    <= BIN;
                bcd_sr    <= '0;
                cnt       <= '0;
                ovfl_cap  <= BIN_OVFL;
                last_bin  <= BIN;
                last_ovfl <= BIN_OVFL;
            end
            // Correction uses the pre-shift digits; adjust and shift land together
            if (shift_c) begin
                bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
                bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
                cnt    <= cnt + CNT_W'(1);
            end
            if (publish_c) begin
                BCD_OUT  <= bcd_sr;
                BLANK    <= blank_c;
                OVFL_OUT <= ovfl_cap;
            end
        end
    end

endmodule

// File: tb/tb_time_bcd_converter.sv
// Directed bench for time_bcd_converter: one manual-start and one auto-update instance.
module tb_time_bcd_converter;

    typedef struct {
        logic [19:0] bcd;
        logic [4:0]  blank;
        logic        ovfl;
    } exp_t;

    logic        MCLK = 1'b0;
    logic        RESET;

    logic [15:0] bin_m;
    logic        ovfl_m;
    logic        start_m;
    logic        busy_m;
    logic [19:0] bcd_m;
    logic [4:0]  blank_m;
    logic        ovflo_m;
    logic        valid_m;

    logic [15:0] bin_a;
    logic        ovfl_a;
    logic        start_a;
    logic        busy_a;
    logic [19:0] bcd_a;
    logic [4:0]  blank_a;
    logic        ovflo_a;
    logic        valid_a;

    int   total = 0;
    int   bad   = 0;
    exp_t q_m[$];
    exp_t q_a[$];
    exp_t em;
    exp_t ea;

    time_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5), .AUTO_UPDATE(1'b0)) u_dut_m (
        .MCLK       (MCLK),
        .RESET      (RESET),
        .BIN        (bin_m),
        .BIN_OVFL   (ovfl_m),
        .CONV_START (start_m),
        .BUSY       (busy_m),
        .BCD_OUT    (bcd_m),
        .BLANK      (blank_m),
        .OVFL_OUT   (ovflo_m),
        .BCD_VALID  (valid_m)
    );

    time_bcd_converter #(.BIN_WIDTH(16), .DIGITS(5), .AUTO_UPDATE(1'b1)) u_dut_a (
        .MCLK       (MCLK),
        .RESET      (RESET),
        .BIN        (bin_a),
        .BIN_OVFL   (ovfl_a),
        .CONV_START (start_a),
        .BUSY       (busy_a),
        .BCD_OUT    (bcd_a),
        .BLANK      (blank_a),
        .OVFL_OUT   (ovflo_a),
        .BCD_VALID  (valid_a)
    );

    always #5 MCLK = ~MCLK;

    // Decimal reference built by repeated division, independent of double-dabble
    function automatic exp_t model(input int unsigned v, input logic ov);
        exp_t        e;
        int unsigned t;
        logic        z;
        t = v;
        for (int i = 0; i < 5; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        e.blank = '0;
        for (int k = 1; k < 5; k++) begin
            z = 1'b1;
            for (int j = k; j < 5; j++) begin
                if (e.bcd[4*j +: 4] != 4'd0) z = 1'b0;
            end
            e.blank[k] = z;
        end
        e.ovfl = ov;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge MCLK) begin
        if (!RESET && valid_m) begin
            total++;
            assert (q_m.size() != 0) else begin
                bad++;
                $error("FAIL m_unexpected_valid observed=%0h expected=none", bcd_m);
            end
            if (q_m.size() != 0) begin
                em = q_m.pop_front();
                chk("m_bcd", 32'(bcd_m), 32'(em.bcd));
                chk("m_blank", 32'(blank_m), 32'(em.blank));
                chk("m_ovfl", 32'(ovflo_m), 32'(em.ovfl));
            end
        end
    end

    always @(negedge MCLK) begin
        if (!RESET && valid_a) begin
            total++;
            assert (q_a.size() != 0) else begin
                bad++;
                $error("FAIL a_unexpected_valid observed=%0h expected=none", bcd_a);
            end
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                chk("a_bcd", 32'(bcd_a), 32'(ea.bcd));
                chk("a_blank", 32'(blank_a), 32'(ea.blank));
                chk("a_ovfl", 32'(ovflo_a), 32'(ea.ovfl));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((q_m.size() != 0 || q_a.size() != 0) && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        chk("drain", 32'(q_m.size() + q_a.size()), 32'd0);
    endtask

    // Manual conversion with latency, BUSY-width and pulse-width checks; entered at a negedge
    task automatic run_manual(input logic [15:0] v, input logic ov);
        int k;
        int busy_n;
        bin_m   = v;
        ovfl_m  = ov;
        start_m = 1'b1;
        q_m.push_back(model(int'(v), ov));
        @(posedge MCLK);
        @(negedge MCLK);
        start_m = 1'b0;
        k = 0;
        busy_n = 0;
        while (!valid_m && k < 40) begin
            busy_n += int'(busy_m);
            @(negedge MCLK);
            k++;
        end
        chk("m_latency", 32'(k), 32'd17);
        chk("m_busy_cycles", 32'(busy_n), 32'd17);
        chk("m_busy_at_valid", 32'(busy_m), 32'd0);
        @(negedge MCLK);
        chk("m_valid_width", 32'(valid_m), 32'd0);
    endtask

    initial begin
        int k;
        RESET   = 1'b1;
        bin_m   = '0;
        ovfl_m  = 1'b0;
        start_m = 1'b0;
        bin_a   = '0;
        ovfl_a  = 1'b0;
        start_a = 1'b0;
        wait_cycles(3);
        chk("rst_bcd", 32'(bcd_m), 32'd0);
        chk("rst_blank", 32'(blank_m), 32'b11110);
        chk("rst_ovfl", 32'(ovflo_m), 32'd0);
        chk("rst_valid", 32'(valid_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_blank_a", 32'(blank_a), 32'b11110);
        RESET = 1'b0;

        // BIN=0 right after reset must not auto-convert
        wait_cycles(25);
        chk("a_idle_after_reset", 32'(busy_a), 32'd0);

        run_manual(16'd0, 1'b0);
        run_manual(16'd12345, 1'b0);
        wait_cycles(30);
        chk("m_hold_no_restart", 32'(busy_m), 32'd0);
        run_manual(16'd65535, 1'b1);

        // Manual: change BIN and pulse start mid-conversion, both ignored
        bin_m   = 16'd305;
        ovfl_m  = 1'b0;
        start_m = 1'b1;
        q_m.push_back(model(305, 1'b0));
        @(posedge MCLK);
        @(negedge MCLK);
        start_m = 1'b0;
        wait_cycles(5);
        bin_m   = 16'd999;
        start_m = 1'b1;
        @(negedge MCLK);
        start_m = 1'b0;
        wait_cycles(50);
        chk("m_no_second_conv", 32'(busy_m), 32'd0);
        chk("m_result_kept", 32'(bcd_m), 32'h00305);
        wait_drain(10);

        // Auto: mid-conversion change is caught and converted on first IDLE cycle
        bin_a = 16'd305;
        q_a.push_back(model(305, 1'b0));
        @(posedge MCLK);
        wait_cycles(5);
        bin_a   = 16'd999;
        start_a = 1'b1;
        q_a.push_back(model(999, 1'b0));
        @(negedge MCLK);
        start_a = 1'b0;
        k = 0;
        while (!valid_a && k < 40) begin
            @(negedge MCLK);
            k++;
        end
        chk("a_first_valid_seen", 32'(valid_a), 32'd1);
        @(negedge MCLK);
        chk("a_restart_after_idle", 32'(busy_a), 32'd1);
        wait_drain(60);

        // Reset mid-SHIFT aborts without a result
        bin_m   = 16'd4321;
        start_m = 1'b1;
        @(posedge MCLK);
        @(negedge MCLK);
        start_m = 1'b0;
        wait_cycles(8);
        chk("m_busy_pre_reset", 32'(busy_m), 32'd1);
        q_a.push_back(model(999, 1'b0));
        RESET = 1'b1;
        #1;
        chk("abort_bcd", 32'(bcd_m), 32'd0);
        chk("abort_blank", 32'(blank_m), 32'b11110);
        chk("abort_ovfl", 32'(ovflo_m), 32'd0);
        chk("abort_busy", 32'(busy_m), 32'd0);
        chk("abort_valid", 32'(valid_m), 32'd0);
        wait_cycles(2);
        RESET = 1'b0;
        wait_drain(60);
        wait_cycles(20);
        chk("m_after_abort_bcd", 32'(bcd_m), 32'd0);

        // Auto stepping: one result per step
        bin_a = 16'd0;
        q_a.push_back(model(0, 1'b0));
        wait_cycles(40);
        bin_a = 16'd1;
        q_a.push_back(model(1, 1'b0));
        wait_cycles(40);
        chk("a_step1", 32'(bcd_a), 32'h00001);
        bin_a = 16'd2;
        q_a.push_back(model(2, 1'b0));
        wait_cycles(40);
        chk("a_step2", 32'(bcd_a), 32'h00002);

        // Start pulse coinciding with an auto trigger gives one conversion
        bin_a   = 16'd7;
        start_a = 1'b1;
        q_a.push_back(model(7, 1'b0));
        @(negedge MCLK);
        start_a = 1'b0;
        wait_cycles(40);
        chk("a_single_conv_idle", 32'(busy_a), 32'd0);

        wait_drain(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_bcd_converter.md
Name: time_bcd_converter

Overview:
- Downstream consumer of the elapsed-time counter in the tempsense path.
- Takes the 16-bit unsigned seconds value and its overflow flag and converts the value to packed BCD with a sequential double-dabble, one bit per clock.
- Also produces a leading-zero blanking mask, so the display/status stage needs no arithmetic of its own.

Parameters:
- BIN_WIDTH, 16: binary input width. Iteration count equals BIN_WIDTH.
- DIGITS, 5: BCD digit count. Must satisfy 10^DIGITS > 2^BIN_WIDTH-1.
- AUTO_UPDATE, 1: 1 = conversion self-starts on any change of BIN or BIN_OVFL. 0 = conversion starts only on CONV_START.

Ports:
- MCLK  in  1  master clock, all logic on posedge
- RESET  in  1  asynchronous, active-high reset
- BIN  in  BIN_WIDTH  elapsed time in seconds from the time counter
- BIN_OVFL  in  1  overflow flag from the time counter
- CONV_START  in  1  single-cycle conversion request
- BUSY  out  1  high whenever FSM is not IDLE
- BCD_OUT  out  4*DIGITS  packed BCD result, digit 0 in [3:0]
- BLANK  out  DIGITS  1 = digit is a leading zero; bit 0 always 0
- OVFL_OUT  out  1  BIN_OVFL value captured with the converted sample
- BCD_VALID  out  1  one-cycle pulse when new BCD_OUT, BLANK and OVFL_OUT are present

Behaviour:
- Reset (async, RESET=1):
  - Outputs: BCD_OUT=0, BLANK={DIGITS-1 ones, 0}, OVFL_OUT=0, BCD_VALID=0.
  - Internal: FSM=IDLE, iteration counter=0, last_bin=0, last_ovfl=0. BUSY is therefore 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = CONV_START, OR (AUTO_UPDATE and (BIN != last_bin or BIN_OVFL != last_ovfl)).
  - On a start edge E0, and only on E0:
    - bin_sr <= BIN; bcd_sr <= 0; cnt <= 0; ovfl_cap <= BIN_OVFL.
    - last_bin <= BIN; last_ovfl <= BIN_OVFL.
    - FSM -> SHIFT.
- SHIFT, one edge per iteration:
  - Every bcd_sr nibble >= 5 gets +3.
  - {bcd_sr, bin_sr} then shifts left by 1; cnt increments.
  - When cnt == BIN_WIDTH-1, FSM -> DONE. SHIFT therefore occupies exactly BIN_WIDTH edges (E1..E16).
- DONE (edge E17):
  - BCD_OUT <= bcd_sr; OVFL_OUT <= ovfl_cap; BLANK <= computed mask; BCD_VALID <= 1.
  - FSM -> IDLE.
  - BCD_VALID clears on the next edge. Pulse width is exactly 1 cycle.
- Latency: BCD_VALID is high in the cycle after E(BIN_WIDTH+1). That is 17 cycles after the start edge at defaults.
- BLANK mask: bit k = 1 iff digits k..DIGITS-1 are all zero and k > 0.
  - Value 0 -> mask 5'b11110.
  - Value 305 -> mask 5'b11000.
- BUSY is combinational, equal to (state != IDLE). It is high from after E0 through DONE, and low in the cycle BCD_VALID is high.
- Width rules:
  - No truncation: bcd_sr is 4*DIGITS bits.
  - BIN = 65535 produces 0x65535.
  - Nibble adjust uses the pre-shift value. Adjust and shift complete in the same cycle.
- Boundary conditions:
  - CONV_START or input change while BUSY is ignored; nothing is queued.
  - With AUTO_UPDATE=1, a change during BUSY is still caught: it differs from last_bin, so it triggers a new conversion on the first IDLE cycle.
  - BIN changing mid-conversion does not affect the result; the sample is taken at E0.
  - With AUTO_UPDATE=1, a held BIN equal to last_bin never restarts conversion.
  - After reset, BIN=0 does not auto-convert. The reset outputs already represent 0.
  - CONV_START and an auto-trigger in the same IDLE cycle produce one conversion.
  - BIN_OVFL does not alter the arithmetic. The saturated input (65535) converts normally; the flag is only carried through.
  - RESET mid-SHIFT or in DONE aborts immediately. The previous BCD_OUT is lost (reset values), and no BCD_VALID pulse is emitted.

Decomposition:
- Shared tempsense package holds:
  - FSM state encoding (IDLE/SHIFT/DONE).
  - Defaults for BIN_WIDTH and DIGITS, shared with the time counter's 16-bit width.
  - The packed-BCD digit type (4-bit nibble).
- One sub-module is natural: bcd_nibble_adj. It is combinational: 4-bit in, +3 if >=5, 4-bit out, instantiated DIGITS times via generate.
- The leading-zero mask stays inline.

Test Plan:
- Reset, then CONV_START with BIN=0 -> 17 cycles later BCD_VALID=1, BCD_OUT=0x00000, BLANK=5'b11110, OVFL_OUT=0. BUSY high for exactly 17 cycles.
- AUTO_UPDATE=0, BIN=12345, CONV_START pulse -> BCD_OUT=0x12345, BLANK=5'b00000, single-cycle BCD_VALID. No restart while BIN is held.
- BIN=65535, BIN_OVFL=1, CONV_START -> BCD_OUT=0x65535, OVFL_OUT=1.
- BIN=305 converting; at cycle 5 set BIN=999 and pulse CONV_START:
  - AUTO_UPDATE=0 -> first result 0x00305, BLANK=5'b11000, then no second conversion.
  - AUTO_UPDATE=1 -> second conversion auto-starts on the first IDLE cycle and yields 0x00999.
- RESET asserted at cycle 8 of SHIFT -> outputs immediately return to reset values, BUSY=0, and no BCD_VALID pulse.
- AUTO_UPDATE=1, BIN stepped 0 -> 1 -> 2 every 40 cycles -> exactly one BCD_VALID per step, results 0x00001 and 0x00002.
